// File: rtl/rmm_pipe_lanes.sv
// rmm_pipe_lanes: two-stage multi-lane pipe computing unsigned products (MUL) or
// exponent max and alignment offsets (EXP), with valid/ready on both sides.
module rmm_pipe_lanes #(
  parameter int W     = 4,
  parameter int LANES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_mode,
  input  logic [LANES*W-1:0]     in_a,
  input  logic [LANES*W-1:0]     in_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_mode,
  output logic [LANES*2*W-1:0]   out_pp,
  output logic [LANES*W-1:0]     out_emax,
  output logic [LANES*W-1:0]     out_oe1,
  output logic [LANES*W-1:0]     out_oe2
);
  logic adv1, adv2;
  logic s1_valid_q, s2_valid_q, s1_mode_q, s2_mode_q;
  logic [LANES*W-1:0]   s1_a_q, s1_b_q;
  logic [LANES-1:0]     s1_ge_d, s1_ge_q;
  logic [LANES*2*W-1:0] s1_pp_d, s1_pp_q, s2_pp_d, s2_pp_q;
  logic [LANES*W-1:0]   s2_emax_d, s2_emax_q, s2_oe1_d, s2_oe1_q, s2_oe2_d, s2_oe2_q;
  assign adv2     = !s2_valid_q || out_ready;
  assign adv1     = !s1_valid_q || adv2;
  assign in_ready = adv1;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [W-1:0] a, b, mx;
    assign a  = s1_a_q[i*W +: W];
    assign b  = s1_b_q[i*W +: W];
    // S1 resolves the compare and the full-width product; S2 only selects and subtracts
    assign s1_ge_d[i]                = in_a[i*W +: W] >= in_b[i*W +: W];
    assign s1_pp_d[i*2*W +: 2*W]     = (2*W)'(in_a[i*W +: W]) * (2*W)'(in_b[i*W +: W]);
    assign mx                        = s1_ge_q[i] ? a : b;
    assign s2_emax_d[i*W +: W]       = s1_mode_q ? mx : '0;
    assign s2_oe1_d[i*W +: W]        = s1_mode_q ? mx - a : '0;
    assign s2_oe2_d[i*W +: W]        = s1_mode_q ? mx - b : '0;
    assign s2_pp_d[i*2*W +: 2*W]     = s1_mode_q ? '0 : s1_pp_q[i*2*W +: 2*W];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_mode_q  <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_ge_q    <= '0;
      s1_pp_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_mode_q  <= 1'b0;
      s2_pp_q    <= '0;
      s2_emax_q  <= '0;
      s2_oe1_q   <= '0;
      s2_oe2_q   <= '0;
    end else begin
      if (adv1) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_mode_q <= in_mode;
          s1_a_q    <= in_a;
          s1_b_q    <= in_b;
          s1_ge_q   <= s1_ge_d;
          s1_pp_q   <= s1_pp_d;
        end
      end
      if (adv2) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_mode_q <= s1_mode_q;
          s2_pp_q   <= s2_pp_d;
          s2_emax_q <= s2_emax_d;
          s2_oe1_q  <= s2_oe1_d;
          s2_oe2_q  <= s2_oe2_d;
        end
      end
    end
  end
  assign out_valid = s2_valid_q;
  assign out_mode  = s2_mode_q;
  assign out_pp    = s2_pp_q;
  assign out_emax  = s2_emax_q;
  assign out_oe1   = s2_oe1_q;
  assign out_oe2   = s2_oe2_q;
endmodule
